chunked_adder: RTL

- Parametrised, multi-cycle adder/subtractor for the ALU datapath; successor to the single-cycle half adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, rippling the carry between chunks through a register.
- Uses valid/ready handshakes on both sides, so it can sit between an operand source and a result consumer that may stall.
- Produces sum, carry-out and signed overflow.

---
 rtl/chunked_adder.sv | 108 ++++++++++
 1 files changed

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle adder/subtractor that processes CHUNK bits per
// clock and ripples the carry between chunks through a register.
// N = WIDTH/CHUNK cycles per operation; valid/ready handshake on both sides.
//
// Ports:
//   clk        - clock, rising-edge active
//   rst_n      - synchronous active-low reset
//   in_valid   - operands a, b, sub presented
//   in_ready   - block accepts operands this cycle
//   a, b       - WIDTH-bit operands
//   sub        - 0: a+b, 1: a-b
//   out_valid  - result available
//   out_ready  - consumer takes result this cycle
//   sum        - result modulo 2^WIDTH
//   carry_out  - carry from MSB (subtract: 1 = no borrow)
//   overflow   - signed two's-complement overflow
module chunked_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = CHUNK + 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [CW-1:0]    csum;
  logic [CHUNK-1:0] s;
  logic             c;
  logic             accept;

  assign in_ready  = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // Operand registers shift right one chunk per RUN cycle, so the active
  // chunk is always the low CHUNK bits. On the last chunk the low chunk holds
  // the operand MSBs used for the overflow test. The sum register shifts in
  // from the top, so after N chunks every slice sits at i*CHUNK.
  always_comb begin
    csum = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]} + CW'(carry);
    s    = csum[CHUNK-1:0];
    c    = csum[CHUNK];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      // Only possible in IDLE, or in DONE while the result is consumed.
      a_r   <= a;
      b_r   <= sub ? ~b : b;
      carry <= sub;
      idx   <= '0;
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          a_r   <= a_r >> CHUNK;
          b_r   <= b_r >> CHUNK;
          sum   <= (sum >> CHUNK) | (WIDTH'(s) << (WIDTH - CHUNK));
          carry <= c;
          if (idx == LAST) begin
            carry_out <= c;
            overflow  <= (a_r[CHUNK-1] == b_r[CHUNK-1]) && (s[CHUNK-1] != a_r[CHUNK-1]);
            idx       <= '0;
            state     <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule
